// File: rtl/ctrl_pipe.sv
// Control-word pipeline: carries a decoded control word and its valid bit through DEPTH stages
// with per-stage stall (freezing everything upstream), bubble insertion, flush and statistics counters.
module ctrl_pipe #(
   parameter int              WIDTH  = 30,
   parameter int              DEPTH  = 4,
   parameter logic [WIDTH-1:0] BUBBLE = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         in_ctrl,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DEPTH-1:0]         stall,
   input  logic [DEPTH-1:0]         flush,
   output logic [DEPTH*WIDTH-1:0]   stage_ctrl,
   output logic [DEPTH-1:0]         stage_valid,
   output logic                     retire,
   output logic [15:0]              stall_cycles,
   output logic [15:0]              retire_count
);

   logic [DEPTH-1:0][WIDTH-1:0] ctrl_q, ctrl_d, up_ctrl;
   logic [DEPTH-1:0]            valid_q, valid_d, up_valid;
   logic [DEPTH-1:0]            hold, up_hold;
   logic [15:0]                 stall_cnt_q, stall_cnt_d;
   logic [15:0]                 retire_cnt_q, retire_cnt_d;

   // A stall at stage k freezes every stage at or above it (indices 0..k).
   always_comb begin
      hold = '0;
      for (int i = 0; i < DEPTH; i++) begin
         hold[i] = ((stall >> i) != '0);
      end
   end

   assign up_hold = hold << 1;

   always_comb begin
      up_ctrl     = '0;
      up_valid    = '0;
      up_ctrl[0]  = in_valid ? in_ctrl : BUBBLE;
      up_valid[0] = in_valid;
      for (int i = 1; i < DEPTH; i++) begin
         up_ctrl[i]  = ctrl_q[i-1];
         up_valid[i] = valid_q[i-1];
      end
   end

   always_comb begin
      ctrl_d  = ctrl_q;
      valid_d = valid_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (flush[i]) begin
            ctrl_d[i]  = BUBBLE;
            valid_d[i] = 1'b0;
         end else if (!hold[i]) begin
            if (up_hold[i]) begin
               ctrl_d[i]  = BUBBLE;
               valid_d[i] = 1'b0;
            end else begin
               ctrl_d[i]  = up_ctrl[i];
               valid_d[i] = up_valid[i];
            end
         end
      end
   end

   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      retire_cnt_d = retire_cnt_q;
      if (hold[0] && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
      if (valid_q[DEPTH-1] && !hold[DEPTH-1]) begin
         retire_cnt_d = retire_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q       <= {DEPTH{BUBBLE}};
         valid_q      <= '0;
         stall_cnt_q  <= '0;
         retire_cnt_q <= '0;
      end else begin
         ctrl_q       <= ctrl_d;
         valid_q      <= valid_d;
         stall_cnt_q  <= stall_cnt_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign in_ready     = !hold[0];
   assign stage_ctrl   = ctrl_q;
   assign stage_valid  = valid_q;
   assign retire       = valid_q[DEPTH-1];
   assign stall_cycles = stall_cnt_q;
   assign retire_count = retire_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed scenarios plus randomized traffic against a stage-array model.
module tb_ctrl_pipe;
   localparam int D = 4;
   localparam int W = 30;
   localparam logic [W-1:0] WA = 30'h0000_0A11;
   localparam logic [W-1:0] WB = 30'h0000_0B22;
   localparam logic [W-1:0] WC = 30'h0000_0C33;
   localparam logic [W-1:0] WD = 30'h0000_0D44;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [W-1:0]   in_ctrl = '0;
   logic           in_valid = 1'b0;
   logic [D-1:0]   stall = '0;
   logic [D-1:0]   flush = '0;
   logic           in_ready, retire;
   logic [D*W-1:0] stage_ctrl;
   logic [D-1:0]   stage_valid;
   logic [15:0]    stall_cycles, retire_count;

   logic           rst_a = 1'b1;
   logic [W-1:0]   in_ctrl_a = '0;
   logic           in_valid_a = 1'b0;
   logic [D-1:0]   stall_a = '0;
   logic [D-1:0]   flush_a = '0;
   logic           in_ready_a, retire_a;
   logic [D*W-1:0] stage_ctrl_a;
   logic [D-1:0]   stage_valid_a;
   logic [15:0]    stall_cycles_a, retire_count_a;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [W-1:0] m_ctrl [D];
   logic         m_valid [D];
   int           m_stall_cnt = 0;
   int           m_retire_cnt = 0;

   always #5 clk = ~clk;

   ctrl_pipe #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .reset(rst), .in_ctrl(in_ctrl), .in_valid(in_valid), .in_ready(in_ready),
      .stall(stall), .flush(flush), .stage_ctrl(stage_ctrl), .stage_valid(stage_valid),
      .retire(retire), .stall_cycles(stall_cycles), .retire_count(retire_count));

   ctrl_pipe #(.WIDTH(W), .DEPTH(D)) dut_aux (
      .clk(clk), .reset(rst_a), .in_ctrl(in_ctrl_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .stall(stall_a), .flush(flush_a), .stage_ctrl(stage_ctrl_a), .stage_valid(stage_valid_a),
      .retire(retire_a), .stall_cycles(stall_cycles_a), .retire_count(retire_count_a));

   initial begin
      for (int i = 0; i < D; i++) begin
         m_ctrl[i]  = '0;
         m_valid[i] = 1'b0;
      end
   end

   // Stages at or below the highest stalled index are frozen.
   task automatic model_step();
      int frz;
      logic [W-1:0] nc [D];
      logic         nv [D];
      if (rst) begin
         for (int i = 0; i < D; i++) begin
            m_ctrl[i]  = '0;
            m_valid[i] = 1'b0;
         end
         m_stall_cnt  = 0;
         m_retire_cnt = 0;
         return;
      end
      frz = -1;
      for (int j = 0; j < D; j++) if (stall[j]) frz = j;
      if (frz >= 0 && m_stall_cnt < 65535) m_stall_cnt++;
      if (m_valid[D-1] && frz < D-1) m_retire_cnt = (m_retire_cnt + 1) % 65536;
      for (int i = 0; i < D; i++) begin
         if (flush[i]) begin
            nc[i] = '0; nv[i] = 1'b0;
         end else if (i <= frz) begin
            nc[i] = m_ctrl[i]; nv[i] = m_valid[i];
         end else if (i == frz + 1 && i > 0) begin
            nc[i] = '0; nv[i] = 1'b0;
         end else if (i == 0) begin
            nc[i] = in_valid ? in_ctrl : '0; nv[i] = in_valid;
         end else begin
            nc[i] = m_ctrl[i-1]; nv[i] = m_valid[i-1];
         end
      end
      for (int i = 0; i < D; i++) begin
         m_ctrl[i]  = nc[i];
         m_valid[i] = nv[i];
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; stall = '0; flush = '0; in_valid = 1'b0;
      cyc();
      rst = 1'b0;
   endtask

   task automatic fill();
      logic [W-1:0] seq [4];
      seq[0] = WD; seq[1] = WC; seq[2] = WB; seq[3] = WA;
      for (int k = 0; k < 4; k++) begin
         in_ctrl = seq[k]; in_valid = 1'b1;
         cyc();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 4'b0100;
      #1;
      n_vec++;
      if (in_ready !== 1'b0) begin
         n_err++; $display("FAIL reset_in_ready_stalled: got %b expected 0", in_ready);
      end
      cyc();
      n_vec++;
      if (stage_valid !== 4'b0000 || stage_ctrl !== '0) begin
         n_err++; $display("FAIL reset_stages: valid %b ctrl %h expected 0", stage_valid, stage_ctrl);
      end
      n_vec++;
      if (stall_cycles !== 16'd0 || retire_count !== 16'd0) begin
         n_err++; $display("FAIL reset_counters: got %h/%h expected 0/0", stall_cycles, retire_count);
      end
      stall = '0;
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_in_ready_free: got %b expected 1", in_ready);
      end
      rst = 1'b0;
   endtask

   task automatic test_stream();
      do_reset();
      for (int k = 1; k <= 9; k++) begin
         in_ctrl = W'(k); in_valid = (k <= 5);
         cyc();
         if (k == 4) begin
            n_vec++;
            if (stage_ctrl !== {30'd1, 30'd2, 30'd3, 30'd4} || stage_valid !== 4'b1111 || retire !== 1'b1) begin
               n_err++; $display("FAIL stream_full: got %h v=%b r=%b expected 1,2,3,4 v=1111 r=1",
                                 stage_ctrl, stage_valid, retire);
            end
         end
      end
      in_valid = 1'b0;
      n_vec++;
      if (retire_count !== 16'd5 || stage_valid !== 4'b0000) begin
         n_err++; $display("FAIL stream_retired: count %0d valid %b expected 5 0000", retire_count, stage_valid);
      end
   endtask

   task automatic test_stall();
      do_reset();
      fill();
      stall = 4'b0100;
      #1;
      n_vec++;
      if (in_ready !== 1'b0 || stage_ctrl[3*W +: W] !== WD) begin
         n_err++; $display("FAIL stall_entry: ready %b stage3 %h expected 0 %h", in_ready, stage_ctrl[3*W +: W], WD);
      end
      for (int k = 0; k < 2; k++) begin
         cyc();
         n_vec++;
         if (stage_ctrl !== {30'd0, WC, WB, WA} || stage_valid !== 4'b0111 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL stall_frozen: got %h v=%b ready=%b expected %h v=0111 ready=0",
                              stage_ctrl, stage_valid, in_ready, {30'd0, WC, WB, WA});
         end
      end
      n_vec++;
      if (stall_cycles !== 16'd2) begin
         n_err++; $display("FAIL stall_count: got %0d expected 2", stall_cycles);
      end
      stall = '0;
      cyc();
      n_vec++;
      if (stage_ctrl[3*W +: W] !== WC || stage_valid !== 4'b1110) begin
         n_err++; $display("FAIL stall_release: stage3 %h v=%b expected %h v=1110", stage_ctrl[3*W +: W], stage_valid, WC);
      end
   endtask

   task automatic test_flush();
      do_reset();
      fill();
      flush = 4'b0011;
      cyc();
      flush = '0;
      n_vec++;
      if (stage_ctrl !== {WC, WB, 30'd0, 30'd0} || stage_valid !== 4'b1100) begin
         n_err++; $display("FAIL flush_low: got %h v=%b expected %h v=1100", stage_ctrl, stage_valid, {WC, WB, 30'd0, 30'd0});
      end
   endtask

   task automatic test_flush_stall();
      do_reset();
      fill();
      flush = 4'b0010; stall = 4'b0010;
      cyc();
      flush = '0; stall = '0;
      n_vec++;
      if (stage_ctrl !== {WC, 30'd0, 30'd0, WA} || stage_valid !== 4'b1001) begin
         n_err++; $display("FAIL flush_stall: got %h v=%b expected %h v=1001", stage_ctrl, stage_valid, {WC, 30'd0, 30'd0, WA});
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      fill();
      stall = 4'b1000; rst = 1'b1;
      cyc();
      stall = '0; rst = 1'b0;
      n_vec++;
      if (stage_valid !== 4'b0000 || stage_ctrl !== '0 || stall_cycles !== 16'd0 || retire_count !== 16'd0) begin
         n_err++; $display("FAIL reset_mid: v=%b ctrl=%h cnt=%h/%h expected all zero", stage_valid, stage_ctrl, stall_cycles, retire_count);
      end
      in_ctrl = 30'h1234_567; in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      cyc(); cyc(); cyc();
      n_vec++;
      if (stage_ctrl[3*W +: W] !== 30'h1234_567 || stage_valid !== 4'b1000) begin
         n_err++; $display("FAIL reset_mid_restart: stage3 %h v=%b expected 01234567 v=1000", stage_ctrl[3*W +: W], stage_valid);
      end
   endtask

   task automatic test_counters();
      do_reset();
      rst_a = 1'b1;
      cyc();
      rst_a = 1'b0;
      stall = 4'b0001;
      in_valid_a = 1'b1;
      for (int n = 1; n <= 65540; n++) begin
         in_ctrl_a = W'(n);
         cyc();
         if (n == 65534) begin
            n_vec++;
            if (stall_cycles !== 16'hFFFE) begin
               n_err++; $display("FAIL stall_sat_pre: got %h expected fffe", stall_cycles);
            end
         end
         if (n == 65535 || n == 65540) begin
            n_vec++;
            if (stall_cycles !== 16'hFFFF) begin
               n_err++; $display("FAIL stall_sat: n=%0d got %h expected ffff", n, stall_cycles);
            end
         end
         if (n == 65539) begin
            n_vec++;
            if (retire_count_a !== 16'hFFFF) begin
               n_err++; $display("FAIL retire_pre_wrap: got %h expected ffff", retire_count_a);
            end
         end
         if (n == 65540) begin
            n_vec++;
            if (retire_count_a !== 16'h0000) begin
               n_err++; $display("FAIL retire_wrap: got %h expected 0000", retire_count_a);
            end
         end
      end
      stall = '0; in_valid_a = 1'b0;
   endtask

   task automatic test_random();
      logic [D*W-1:0] exp_sc;
      logic [D-1:0]   exp_sv;
      do_reset();
      for (int k = 0; k < 600; k++) begin
         in_ctrl  = W'($urandom);
         in_valid = ($urandom_range(0, 3) != 0);
         for (int j = 0; j < D; j++) begin
            stall[j] = ($urandom_range(0, 5) == 0);
            flush[j] = ($urandom_range(0, 9) == 0);
         end
         rst = ($urandom_range(0, 49) == 0);
         #1;
         n_vec++;
         if (in_ready !== (stall == '0)) begin
            n_err++; $display("FAIL rand_in_ready: k=%0d got %b expected %b", k, in_ready, (stall == '0));
         end
         cyc();
         for (int i = 0; i < D; i++) begin
            exp_sc[i*W +: W] = m_ctrl[i];
            exp_sv[i]        = m_valid[i];
         end
         n_vec++;
         if (stage_ctrl !== exp_sc || stage_valid !== exp_sv || retire !== exp_sv[D-1]) begin
            n_err++; $display("FAIL rand_stages: k=%0d got %h v=%b r=%b expected %h v=%b", k, stage_ctrl, stage_valid, retire, exp_sc, exp_sv);
         end
         n_vec++;
         if (stall_cycles !== 16'(m_stall_cnt) || retire_count !== 16'(m_retire_cnt)) begin
            n_err++; $display("FAIL rand_counters: k=%0d got %0d/%0d expected %0d/%0d", k, stall_cycles, retire_count, m_stall_cnt, m_retire_cnt);
         end
      end
      rst = 1'b0; stall = '0; flush = '0; in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_flush();
      test_flush_stall();
      test_reset_mid();
      test_counters();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
